// File: rtl/approx_mul_iter.sv
// Iterative approximate multiplier. It adds one 8x8 partial product per clock, with diagonal skipping and LSB truncation.
// Optional macro APPROX_MUL_ZERO_SKIP_EN: a zero operand goes straight to DONE with a zero result.
module approx_mul_iter #(
    parameter int WIDTH  = 16,
    parameter int N_SKIP = 0,
    parameter int N_LSB  = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out,
    output logic               busy
);
    localparam int K  = WIDTH / 8;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam int PW = 2 * WIDTH;
    localparam logic [15:0] LSB_MASK = ~((16'd1 << N_LSB) - 16'd1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, next_state;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [PW-1:0]   acc, term, sum;
    logic [CW-1:0]   ci, cj;
    logic [7:0]      chunk_a, chunk_b;
    logic [15:0]     prod;
    logic            last, accept;
    int              diag;

    assign in_ready = (state == IDLE) && !reset;
    assign accept   = in_valid && in_ready;
    assign last     = (ci == CW'(K - 1)) && (cj == CW'(K - 1));

    // NOTE: combinational blocks use blocking '=' and give every output a default first, so no latch is inferred.
    always_comb begin
        chunk_a = a_reg[{ci, 3'b000} +: 8];
        chunk_b = b_reg[{cj, 3'b000} +: 8];
        diag    = int'(ci) + int'(cj);
        prod    = (16'(chunk_a) * 16'(chunk_b)) & LSB_MASK;
        term    = PW'(prod) << (8 * diag);
        if (diag < N_SKIP)
            term = '0;
        sum = acc + term;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef APPROX_MUL_ZERO_SKIP_EN
                    next_state = ((a == '0) || (b == '0)) ? DONE : RUN;
`else
                    next_state = RUN;
`endif
                end
            end
            RUN:     if (last) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= next_state;
            out_valid <= (next_state == DONE);
            busy      <= (next_state != IDLE);
            if ((state == RUN) && last)
                out <= sum;
`ifdef APPROX_MUL_ZERO_SKIP_EN
            if (accept && ((a == '0) || (b == '0)))
                out <= '0;
`endif
        end
    end

    // NOTE: operand, accumulator and index registers are left unreset on purpose, because IDLE reloads them before each use.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            ci    <= '0;
            cj    <= '0;
        end else if (state == RUN) begin
            acc <= sum;
            if (cj == CW'(K - 1)) begin
                cj <= '0;
                ci <= ci + CW'(1);
            end else begin
                cj <= cj + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_approx_mul_iter.sv
// Bench for approx_mul_iter. It runs three WIDTH=16 variants in lockstep and one WIDTH=32 instance.
// A cycle-level reference model checks each of them.
module tb_approx_mul_iter;

    typedef struct packed {
        logic        busy;
        logic        valid;
        logic [7:0]  left;
        logic [63:0] res;
        logic [63:0] out;
    } mstate_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] a16, b16;
    logic        iv16, or16;
    logic [2:0]  ir16, ov16, busy16;
    logic [31:0] o16 [3];
    logic [31:0] a32, b32;
    logic        iv32, or32, ir32, ov32, busy32;
    logic [63:0] o32;

    int vectors = 0;
    int miscompares = 0;
    mstate_t m16 [3];
    mstate_t m32;

    always #5 clk = ~clk;

    approx_mul_iter #(.WIDTH(16), .N_SKIP(0), .N_LSB(0)) u_exact (
        .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16[0]), .a(a16), .b(b16),
        .out_valid(ov16[0]), .out_ready(or16), .out(o16[0]), .busy(busy16[0]));
    approx_mul_iter #(.WIDTH(16), .N_SKIP(0), .N_LSB(4)) u_trunc (
        .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16[1]), .a(a16), .b(b16),
        .out_valid(ov16[1]), .out_ready(or16), .out(o16[1]), .busy(busy16[1]));
    approx_mul_iter #(.WIDTH(16), .N_SKIP(1), .N_LSB(0)) u_skip (
        .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16[2]), .a(a16), .b(b16),
        .out_valid(ov16[2]), .out_ready(or16), .out(o16[2]), .busy(busy16[2]));
    approx_mul_iter #(.WIDTH(32), .N_SKIP(0), .N_LSB(0)) u_w32 (
        .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .out_valid(ov32), .out_ready(or32), .out(o32), .busy(busy32));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Result from the chunk-product rules. Each chunk product is truncated, skipped if its diagonal is low, then shifted.
    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input int w, input int nskip, input int nlsb);
        logic [63:0] total = 64'd0;
        logic [63:0] p;
        for (int i = 0; i < w / 8; i++)
            for (int j = 0; j < w / 8; j++) begin
                p = 64'((x >> (8 * i)) & 32'hFF) * 64'((y >> (8 * j)) & 32'hFF);
                p = p & ~((64'd1 << nlsb) - 64'd1);
                if (i + j >= nskip)
                    total = total + (p << (8 * (i + j)));
            end
        return total;
    endfunction

    // A job is accepted in idle, waits kk adding cycles, then is held until the consumer takes it.
    function automatic mstate_t advance(input mstate_t s, input logic rst, input logic iv,
                                        input logic ordy, input logic zero,
                                        input logic [63:0] res, input int kk);
        if (rst) begin
            s = '0;
        end else if (s.valid) begin
            if (ordy) begin
                s.valid = 1'b0;
                s.busy  = 1'b0;
            end
        end else if (s.busy) begin
            s.left = s.left - 8'd1;
            if (s.left == 8'd0) begin
                s.valid = 1'b1;
                s.out   = s.res;
            end
        end else if (iv) begin
            s.busy = 1'b1;
            s.res  = res;
            s.left = 8'(kk);
            if (zero) begin
                s.valid = 1'b1;
                s.out   = 64'd0;
            end
        end
        return s;
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) m16[i] = '0;
        m32 = '0;
    end

    always @(posedge clk) begin
        logic z16, z32;
`ifdef APPROX_MUL_ZERO_SKIP_EN
        z16 = (a16 == 16'd0) || (b16 == 16'd0);
        z32 = (a32 == 32'd0) || (b32 == 32'd0);
`else
        z16 = 1'b0;
        z32 = 1'b0;
`endif
        for (int i = 0; i < 3; i++)
            m16[i] = advance(m16[i], reset, iv16, or16, z16,
                             model({16'd0, a16}, {16'd0, b16}, 16, (i == 2) ? 1 : 0, (i == 1) ? 4 : 0), 4);
        m32 = advance(m32, reset, iv32, or32, z32, model(a32, b32, 32, 0, 0), 16);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("out_valid16[%0d]", i), {63'd0, ov16[i]}, {63'd0, m16[i].valid});
            check($sformatf("out16[%0d]", i), {32'd0, o16[i]}, m16[i].out);
        end
        check("busy16", {63'd0, busy16[0]}, {63'd0, m16[0].busy});
        check("in_ready16", {63'd0, ir16[0]}, {63'd0, !m16[0].busy && !reset});
        check("out_valid32", {63'd0, ov32}, {63'd0, m32.valid});
        check("out32", o32, m32.out);
        check("busy32", {63'd0, busy32}, {63'd0, m32.busy});
        check("in_ready32", {63'd0, ir32}, {63'd0, !m32.busy && !reset});
    end

    task automatic op16(input logic [15:0] x, input logic [15:0] y, input int delay,
                        output logic [31:0] r0, output logic [31:0] r1, output logic [31:0] r2);
        int n;
        @(negedge clk);
        a16 = x; b16 = y; iv16 = 1'b1; or16 = (delay == 0);
        @(negedge clk);
        iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        n = 0;
        while (!ov16[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!ov16[0]) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout16: out_valid still low, expected high within 40 cycles");
        end
        r0 = o16[0]; r1 = o16[1]; r2 = o16[2];
        repeat (delay) begin
            @(negedge clk);
            iv16 = 1'($urandom_range(0, 1));
        end
        or16 = 1'b1;
        @(negedge clk);
        iv16 = 1'b0;
    endtask

    task automatic op32(input logic [31:0] x, input logic [31:0] y, input int delay,
                        output logic [63:0] r);
        int n;
        @(negedge clk);
        a32 = x; b32 = y; iv32 = 1'b1; or32 = (delay == 0);
        @(negedge clk);
        iv32 = 1'b0; a32 = $urandom; b32 = $urandom;
        n = 0;
        while (!ov32 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!ov32) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout32: out_valid still low, expected high within 60 cycles");
        end
        r = o32;
        repeat (delay) @(negedge clk);
        or32 = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] r0, r1, r2;
        logic [63:0] r;
        logic [15:0] x, y;
        a16 = '0; b16 = '0; iv16 = 1'b0; or16 = 1'b1;
        a32 = '0; b32 = '0; iv32 = 1'b0; or32 = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("model_trunc", model(32'd1000, 32'd1000, 16, 0, 4), 64'd406080);
        check("model_skip", model(32'd1000, 32'd1000, 16, 1, 0), 64'd946176);
        check("model_w32", model(32'hFFFFFFFF, 32'd2, 32, 0, 0), 64'h1_FFFF_FFFE);

        op16(16'd1000, 16'd1000, 0, r0, r1, r2);
        check("exact_1000", {32'd0, r0}, 64'd1000000);
        check("trunc_1000", {32'd0, r1}, 64'd406080);
        check("skip_1000", {32'd0, r2}, 64'd946176);
        op16(16'hFFFF, 16'hFFFF, 0, r0, r1, r2);
        check("exact_max", {32'd0, r0}, 64'hFFFE_0001);

        op16(16'd1000, 16'd1000, 5, r0, r1, r2);
        check("backpressure", {32'd0, r0}, 64'd1000000);
        op16(16'd7, 16'd9, 0, r0, r1, r2);
        check("after_bp", {32'd0, r0}, 64'd63);

        // Abort during the second RUN cycle.
        @(negedge clk);
        a16 = 16'd1234; b16 = 16'd4321; iv16 = 1'b1; or16 = 1'b1;
        @(negedge clk);
        iv16 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_out", {32'd0, o16[0]}, 64'd0);
        check("rst_valid", {63'd0, ov16[0]}, 64'd0);
        check("rst_busy", {63'd0, busy16[0]}, 64'd0);
        op16(16'd3, 16'd5, 0, r0, r1, r2);
        check("post_rst", {32'd0, r0}, 64'd15);

        for (int i = 0; i <= 59; i++)
            for (int j = 0; j <= 59; j++) begin
                op16(16'(i * 1000), 16'(j * 1000), 0, r0, r1, r2);
                check("sweep", {32'd0, r0}, 64'(i * 1000) * 64'(j * 1000));
            end

        for (int k = 0; k < 80; k++) begin
            x = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            y = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            op16(x, y, $urandom_range(0, 3), r0, r1, r2);
        end

        op32(32'hFFFFFFFF, 32'd2, 0, r);
        check("w32_exact", r, 64'h1_FFFF_FFFE);
        op32(32'd0, 32'd12345, 0, r);
        check("w32_zero", r, 64'd0);
        for (int k = 0; k < 20; k++)
            op32($urandom, $urandom, $urandom_range(0, 2), r);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/approx_mul_iter.md
# approx_mul_iter

Iterative, width-parametrised approximate multiplier, a sequential successor to the fixed-width combinational approximate multipliers. It splits both WIDTH-bit operands into 8-bit chunks and accumulates one 8x8 partial product per clock, applying two tunable approximations: whole-diagonal skipping and per-product LSB truncation. It trades throughput for area and sits behind a valid/ready handshake, so it can be dropped into streaming datapaths or driven directly by a bench.

## Interface
- WIDTH, 16, operand width; multiple of 8, range 8..64; K = WIDTH/8 chunks per operand
- N_SKIP, 0, partial products P(i,j) with i+j < N_SKIP contribute zero; range 0..2K-1
- N_LSB, 0, low N_LSB bits of every 8x8 partial product forced to zero before accumulation; range 0..15
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
- in_valid  input  1  operands a, b are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  multiplicand, unsigned
- b  input  WIDTH  multiplier, unsigned
- out_valid  output  1  result on out is valid
- out_ready  input  1  consumer takes result
- out  output  2*WIDTH  approximate unsigned product
- busy  output  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE. Reset value: IDLE, out=0, out_valid=0, busy=0; in_ready=0 while reset is high.
- in_ready = (state==IDLE) && !reset. Accept on the edge where in_valid && in_ready: latch a, b; clear accumulator; clear index; go to RUN.
- RUN: index n = 0..K*K-1 with i = n / K (chunk of a) and j = n % K (chunk of b). Each cycle: P = a[8i+7:8i] * b[8j+7:8j] (16 bits), P masked by ~((1<<N_LSB)-1), zero if i+j < N_SKIP. Add P << 8(i+j) to a 2*WIDTH accumulator; the sum cannot overflow. After n = K*K-1 is added, go to DONE.
- Skipped products still consume their cycle, so latency is fixed.
- DONE: out = accumulator, out_valid=1, held stable until out_valid && out_ready; then go to IDLE with out_valid=0. out keeps its last value in IDLE and RUN.
- in_ready is low in DONE: no input is accepted on the same edge as output completion.
- N_SKIP=0, N_LSB=0: result is bit-exact a*b.
- Inputs a, b and in_valid are ignored outside IDLE.
- Reset asserted in any state: abort, discard the operation, return to reset values on that edge.

## Timing
- Acceptance at edge E0. Products are added at edges E1..E(K*K). out_valid is high in the cycle after E(K*K).
  - WIDTH=16: 4 RUN cycles, result visible 5 cycles after acceptance.
- Minimum initiation interval: K*K+2 cycles (accept, K*K RUN, one DONE cycle with out_ready high).
- All outputs are registered except in_ready, which is decoded from state and reset.

## Configuration
- APPROX_MUL_ZERO_SKIP_EN defined:
  - If a==0 or b==0 at acceptance, go directly from IDLE to DONE with accumulator=0.
  - out_valid rises the cycle after acceptance.
- Undefined: zero operands take the full K*K RUN cycles. The result is the same.

## Test plan
- Exact mode, WIDTH=16, N_SKIP=0, N_LSB=0: a=1000, b=1000 -> out=1000000. a=65535, b=65535 -> out=0xFFFE0001. out_valid exactly 5 cycles after acceptance.
- Truncation, WIDTH=16, N_LSB=4: a=b=1000 -> out=406080 (P00=53824, P01=P10=688, P11=0).
- Diagonal skip, WIDTH=16, N_SKIP=1: a=b=1000 -> out=946176. Exact sweep over a, b in steps of 1000 up to 59000 with N_SKIP=0 matches a*b.
- Backpressure: hold out_ready low 5 cycles in DONE -> out and out_valid stable, in_ready=0, in_valid pulses ignored. Raise out_ready -> in_ready=1 next cycle and the next operand is accepted.
- Reset mid-RUN: assert reset at the 2nd RUN cycle -> next cycle out=0, out_valid=0, busy=0. After reset deasserts, a=3, b=5 -> out=15.
- WIDTH=32 exact: a=0xFFFFFFFF, b=2 -> out=0x1FFFFFFFE after 16 RUN cycles. With APPROX_MUL_ZERO_SKIP_EN defined, a=0 -> out=0, out_valid one cycle after acceptance.
